// File: rtl/text_console_pkg.sv
// Shared constants, control codes and FSM states for the text console writer.
package text_console_pkg;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam logic [6:0] BLANK = 7'h00;

  localparam logic [6:0] CR = 7'h0D;
  localparam logic [6:0] LF = 7'h0A;
  localparam logic [6:0] BS = 7'h08;
  localparam logic [6:0] FF = 7'h0C;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CLEAR_ROW = 2'd1,
    CLEAR_ALL = 2'd2
  } state_t;
endpackage

// File: rtl/text_console_writer.sv
// Character console writer: consumes ASCII codes, tracks an 80x30 cursor and
// drives the tile RAM write port, blanking rows/screen as the cursor moves.
//
// state     | meaning
// IDLE      | accepting codes, one per cycle
// CLEAR_ROW | blanking the row just entered (cur_y), one tile per cycle
// CLEAR_ALL | blanking the whole screen after reset or FF
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_valid,
  input  logic [6:0]    wr_ascii,
  output logic          wr_ready,
  output logic          tram_we,
  output logic [AW-1:0] tram_addr,
  output logic [6:0]    tram_data,
  output logic [6:0]    cur_x,
  output logic [4:0]    cur_y,
  output logic          busy
);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [6:0]    x_d;
  logic [4:0]    y_d;
  logic          we_d;
  logic [AW-1:0] addr_d;
  logic [6:0]    data_d;
  logic [AW-1:0] row_addr;
  logic          adv_row;

  // row*80 built from shifts so no multiplier is inferred
  function automatic logic [AW-1:0] row_base(input logic [4:0] row);
    logic [AW-1:0] r;
    r = AW'(row);
    return (r << 6) + (r << 4);
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    x_d      = cur_x;
    y_d      = cur_y;
    we_d     = 1'b0;
    addr_d   = tram_addr;
    data_d   = tram_data;
    adv_row  = 1'b0;
    row_addr = row_base(cur_y);

    case (state_q)
      IDLE: begin
        if (wr_valid) begin
          if (wr_ascii >= 7'h20) begin
            we_d   = 1'b1;
            addr_d = row_addr + AW'(cur_x);
            data_d = wr_ascii;
            if (cur_x == 7'(COLS - 1)) begin
              x_d     = '0;
              adv_row = 1'b1;
            end else begin
              x_d = cur_x + 7'd1;
            end
          end else begin
            case (wr_ascii)
              CR: x_d = '0;
              LF: begin
                x_d     = '0;
                adv_row = 1'b1;
              end
              BS: begin
                if (cur_x != 7'd0) begin
                  x_d    = cur_x - 7'd1;
                  we_d   = 1'b1;
                  addr_d = row_addr + AW'(cur_x - 7'd1);
                  data_d = BLANK;
                end
              end
              FF: begin
                x_d     = '0;
                y_d     = '0;
                state_d = CLEAR_ALL;
                cnt_d   = '0;
              end
              default: ;
            endcase
          end
          // every newly entered row is blanked, including the wrap back to row 0
          if (adv_row) begin
            y_d     = (cur_y == 5'(ROWS - 1)) ? 5'd0 : cur_y + 5'd1;
            state_d = CLEAR_ROW;
            cnt_d   = '0;
          end
        end
      end

      CLEAR_ROW: begin
        we_d   = 1'b1;
        addr_d = row_addr + cnt_q;
        data_d = BLANK;
        if (cnt_q == AW'(COLS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end

      CLEAR_ALL: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        data_d = BLANK;
        if (cnt_q == AW'(COLS * ROWS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR_ALL;
      cnt_q     <= '0;
      cur_x     <= '0;
      cur_y     <= '0;
      tram_we   <= 1'b0;
      tram_addr <= '0;
      tram_data <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_x     <= x_d;
      cur_y     <= y_d;
      tram_we   <= we_d;
      tram_addr <= addr_d;
      tram_data <= data_d;
    end
  end

  assign wr_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer: write scoreboard plus
// table-driven cursor vectors and hand-written clear/wrap/reset sequences.
module tb_text_console_writer;
  import text_console_pkg::*;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_valid = 1'b0;
  logic [6:0]    wr_ascii = 7'h00;
  logic          wr_ready;
  logic          tram_we;
  logic [AW-1:0] tram_addr;
  logic [6:0]    tram_data;
  logic [6:0]    cur_x;
  logic [4:0]    cur_y;
  logic          busy;

  text_console_writer #(.AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_valid  (wr_valid),
    .wr_ascii  (wr_ascii),
    .wr_ready  (wr_ready),
    .tram_we   (tram_we),
    .tram_addr (tram_addr),
    .tram_data (tram_data),
    .cur_x     (cur_x),
    .cur_y     (cur_y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [6:0]    data;
  } wr_t;

  typedef struct {
    logic [6:0] code;
    int         exp_x;
    int         exp_y;
    bit         exp_wr;
    int         exp_addr;
    logic [6:0] exp_data;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[8];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic exp_wr(input int a, input logic [6:0] d);
    wr_t e;
    e.addr = AW'(a);
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic exp_blank(input int base, input int n);
    for (int i = 0; i < n; i++) exp_wr(base + i, BLANK);
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (tram_we) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %0d data %0d expected no write", tram_addr, tram_data);
        end else begin
          e = sb.pop_front();
          chk("write_addr", int'(tram_addr), int'(e.addr));
          chk("write_data", int'(tram_data), int'(e.data));
        end
      end
    end
  endtask

  task automatic send(input logic [6:0] code);
    int n;
    n = 0;
    @(negedge clk);
    while (!wr_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (!wr_ready) chk("send_ready_timeout", int'(wr_ready), 1);
    wr_ascii = code;
    wr_valid = 1'b1;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (!wr_ready && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_timeout", int'(wr_ready), 1);
  endtask

  task automatic settle_and_drain(input string name);
    @(negedge clk);
    #1;
    chk(name, sb.size(), 0);
  endtask

  initial begin
    int lows;
    bit found;

    fork
      monitor();
    join_none

    vecs[0] = '{7'h41, 1, 0, 1'b1, 0, 7'h41};
    vecs[1] = '{7'h42, 2, 0, 1'b1, 1, 7'h42};
    vecs[2] = '{BS,    1, 0, 1'b1, 1, BLANK};
    vecs[3] = '{CR,    0, 0, 1'b0, 0, 7'h00};
    vecs[4] = '{BS,    0, 0, 1'b0, 0, 7'h00};
    vecs[5] = '{7'h01, 0, 0, 1'b0, 0, 7'h00};
    vecs[6] = '{7'h7F, 1, 0, 1'b1, 0, 7'h7F};
    vecs[7] = '{7'h20, 2, 0, 1'b1, 1, 7'h20};

    // reset values and the power-up screen clear
    #1 rst_n = 1'b0;
    #2;
    chk("rst_tram_we", int'(tram_we), 0);
    chk("rst_tram_addr", int'(tram_addr), 0);
    chk("rst_tram_data", int'(tram_data), 0);
    chk("rst_cur_x", int'(cur_x), 0);
    chk("rst_cur_y", int'(cur_y), 0);
    chk("rst_wr_ready", int'(wr_ready), 0);
    chk("rst_busy", int'(busy), 1);
    exp_blank(0, COLS * ROWS);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle(3000);
    settle_and_drain("init_clear_count");
    chk("init_cur_x", int'(cur_x), 0);
    chk("init_cur_y", int'(cur_y), 0);
    chk("init_busy", int'(busy), 0);

    // table-driven single codes, back to back
    foreach (vecs[i]) begin
      if (vecs[i].exp_wr) exp_wr(vecs[i].exp_addr, vecs[i].exp_data);
      send(vecs[i].code);
      chk($sformatf("vec%0d_cur_x", i), int'(cur_x), vecs[i].exp_x);
      chk($sformatf("vec%0d_cur_y", i), int'(cur_y), vecs[i].exp_y);
    end
    settle_and_drain("vec_writes_drained");

    // fill row 0 and wrap into row 1
    send(CR);
    chk("cr_cur_x", int'(cur_x), 0);
    for (int i = 0; i < COLS - 1; i++) begin
      exp_wr(i, 7'h78);
      send(7'h78);
    end
    chk("fill_cur_x", int'(cur_x), 79);
    chk("fill_cur_y", int'(cur_y), 0);
    exp_wr(79, 7'h5A);
    exp_blank(80, COLS);
    send(7'h5A);
    chk("wrap_cur_x", int'(cur_x), 0);
    chk("wrap_cur_y", int'(cur_y), 1);
    chk("wrap_ready_drop", int'(wr_ready), 0);
    lows = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (wr_ready) break;
      lows++;
    end
    chk("wrap_busy_cycles", lows, COLS);
    settle_and_drain("wrap_writes_drained");

    // LF down to the last row, then wrap to row 0
    for (int r = 2; r < ROWS; r++) begin
      exp_blank(r * COLS, COLS);
      send(LF);
      wait_idle(200);
    end
    chk("lf_cur_x", int'(cur_x), 0);
    chk("lf_cur_y", int'(cur_y), 29);
    exp_blank(0, COLS);
    send(LF);
    chk("lf_wrap_cur_x", int'(cur_x), 0);
    chk("lf_wrap_cur_y", int'(cur_y), 0);
    wait_idle(200);
    settle_and_drain("lf_wrap_drained");

    // BS / CR corner cases at (5,3)
    for (int r = 1; r <= 3; r++) begin
      exp_blank(r * COLS, COLS);
      send(LF);
      wait_idle(200);
    end
    for (int i = 0; i < 5; i++) begin
      exp_wr(240 + i, 7'h63);
      send(7'h63);
    end
    chk("pos_cur_x", int'(cur_x), 5);
    chk("pos_cur_y", int'(cur_y), 3);
    exp_wr(244, BLANK);
    send(BS);
    chk("bs_cur_x", int'(cur_x), 4);
    chk("bs_cur_y", int'(cur_y), 3);
    send(CR);
    chk("cr_cur_x2", int'(cur_x), 0);
    chk("cr_cur_y2", int'(cur_y), 3);
    chk("cr_no_write", int'(tram_we), 0);
    chk("hold_addr", int'(tram_addr), 244);
    send(BS);
    chk("bs0_cur_x", int'(cur_x), 0);
    chk("bs0_cur_y", int'(cur_y), 3);
    settle_and_drain("bs_cr_drained");

    // FF, then reset in the middle of the screen clear
    exp_blank(0, COLS * ROWS);
    send(FF);
    chk("ff_cur_x", int'(cur_x), 0);
    chk("ff_cur_y", int'(cur_y), 0);
    chk("ff_busy", int'(busy), 1);
    found = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (tram_we && tram_addr == AW'(1000)) begin
        found = 1'b1;
        break;
      end
    end
    chk("ff_reach_1000", int'(found), 1);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_tram_we", int'(tram_we), 0);
    chk("midrst_tram_addr", int'(tram_addr), 0);
    chk("midrst_ready", int'(wr_ready), 0);
    exp_blank(0, COLS * ROWS);
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle(3000);
    settle_and_drain("midrst_clear_count");
    chk("midrst_cur_x", int'(cur_x), 0);
    chk("midrst_cur_y", int'(cur_y), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
